scan_signature_analyzer: RTL and testbench
==========================================

# scan_signature_analyzer

Response end of the scan BIST: sequences `scan_en` for the LFSR-fed 8-bit multiplier scan chain and compacts the serial `scan_out` stream into an 8-bit serial-input signature register (SISR). After the programmed number of capture rounds, it compares the signature against a golden value and reports pass/fail. It sits beside the pattern LFSR and scan chain, shares their `dclk` shift strobe, and replaces the manual `scan_en` switch.

## Interface
- `CHAIN_LEN`, 8: scan-chain length; strobes per shift phase.
- `ROUNDS`, 4: capture rounds per test, ≥1.
- `SEED`, 8'h00: SISR value at reset and on `start`.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `dclk` input 1: one-`clk`-wide shift/capture strobe; the same strobe drives the LFSR and SDFFs.
- `start` input 1: one-cycle pulse that begins a test.
- `scan_out` input 1: serial chain output, sampled only on `dclk` cycles.
- `golden` input 8: expected signature, sampled in DONE.
- `scan_en` output 1: scan/capture select for the chain SDFFs.
- `busy` output 1: high from `start` until DONE.
- `done` output 1: high in DONE until the next `start` or `rst`.
- `pass` output 1: `sig == golden`, valid while `done`.
- `sig` output 8: current SISR contents.

## Operation
- States and transitions:
  - IDLE -> LOAD on `start`.
  - LOAD -> CAPT after `CHAIN_LEN` strobes.
  - CAPT -> SHIFT after 1 strobe.
  - SHIFT -> CAPT after `CHAIN_LEN` strobes if fewer than `ROUNDS` captures have completed; otherwise SHIFT -> DONE.
  - DONE -> LOAD on `start`.
- `scan_en` is a Moore output: 1 in LOAD/SHIFT, 0 in IDLE/CAPT/DONE.
- LOAD fills the chain with LFSR bits. `scan_out` is ignored in LOAD because it carries unknown initial chain contents.
- CAPT: one strobe with `scan_en=0` latches the product `a*b`; the round counter increments.
- SHIFT: on each strobe, `sig <= {sig[6:0], sig[7]^sig[3]^sig[2]^sig[1]^scan_out}`. This uses the same taps as the pattern LFSR. The next pattern loads at the same time.
- Total strobes per test: `CHAIN_LEN + ROUNDS*(CHAIN_LEN+1)`. Compacted bits: `ROUNDS*CHAIN_LEN`.
- `start` in LOAD/CAPT/SHIFT: ignored.
- `start` in IDLE/DONE:
  - `sig` returns to `SEED`; counters and `done` clear.
  - If `start` and `dclk` arrive in the same cycle, `start` wins and that strobe is not counted.
- `dclk` in IDLE/DONE: no effect.
- Strobe counter: `$clog2(CHAIN_LEN+1)` bits, clears at every phase change. Round counter: `$clog2(ROUNDS+1)` bits.

## Timing
- Reset values: state IDLE, `scan_en=0`, `busy=0`, `done=0`, `pass=0`, `sig=SEED`, counters 0.
- `rst` mid-test aborts immediately to the reset values. No partial result is reported.
- State, counters and `sig` update on the `clk` edge ending a `dclk`-high cycle (or a `start` cycle).
- The new `scan_en` is therefore stable for the whole next strobe. The SDFFs sample `scan_en` in the strobe cycle and always see the level of the current phase.
- `busy` rises the cycle after `start`.
- `done` rises the cycle after the final SHIFT strobe.
- `pass` is registered on DONE entry from the final `sig` and the current `golden`. It holds until `start` or `rst`.
- `scan_out` is consumed combinationally in the strobe cycle; it is the pre-edge value of the last SDFF.

## Structure
- The shared BIST package holds:
  - the state enum: IDLE, LOAD, CAPT, SHIFT, DONE;
  - the tap-mask constant 8'b1000_1110, shared with the LFSR;
  - the default `SEED`.
- Sub-module `sisr8`: 8-bit compactor with enable and synchronous load-seed. The FSM and counters stay in the top module.

## Test plan
- Reset, then idle with `dclk` toggling → `scan_en=0`, `busy=0`, `done=0`, `sig=8'h00`, all unchanged.
- `ROUNDS=1`, `start`, 17 strobes → `scan_en` is 1 for strobes 1–8, 0 for strobe 9, 1 for strobes 10–17. `done` rises after strobe 17, not after strobe 16.
- `ROUNDS=1`, `scan_out` stuck at 1, `golden=8'hDE` → `sig=8'hDE`, `pass=1`. Same run with `golden=8'hDF` → `pass=0`.
- `scan_out` stuck at 0, `SEED=0`, `ROUNDS=4`, `golden=8'h00` → `done` after 44 strobes, `pass=1`. `scan_out=1` during LOAD only must leave `sig=8'h00`.
- `start` pulsed during SHIFT → ignored, strobe count unaffected. `start` and `dclk` in the same cycle from DONE → restart, `sig=SEED`, and that strobe is not counted.
- `rst` asserted on strobe 12 of 17 → all outputs at reset values the same cycle. A fresh `start` then completes normally.
- Full system with the LFSR and the real chain, `rst_val=8'hA5`: bench-model signature as `golden` → `pass=1`. One chain bit forced stuck → `pass=0`.

Source files
------------

// File: rtl/scan_signature_analyzer_pkg.sv
// Shared scan-BIST definitions: controller states, LFSR/SISR tap mask,
// default signature seed and the single-step compaction function.
package scan_signature_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Feedback taps at bits 7,3,2,1; the pattern LFSR uses the same polynomial.
    localparam logic [7:0] TAP_MASK     = 8'b1000_1110;
    localparam logic [7:0] DEFAULT_SEED = 8'h00;

    // One SISR step: shift left, feed back the tapped bits XOR the serial input.
    function automatic logic [7:0] sisr_step(input logic [7:0] sig, input logic din);
        return {sig[6:0], (^(sig & TAP_MASK)) ^ din};
    endfunction

endpackage

// File: rtl/scan_signature_analyzer_sisr8.sv
// 8-bit serial-input signature register with enable and synchronous seed load.
// Also exposes the next-state value so the controller can judge the final
// signature in the same cycle it is written.
module sisr8
    import scan_signature_analyzer_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic       din,
    output logic [7:0] sig,
    output logic [7:0] sig_nxt
);

    logic [7:0] sig_d;
    logic [7:0] sig_q;

    // Next signature: seed load has priority over a compaction step.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (that would infer a latch).
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = sisr_step(sig_q, din);
        end
    end

    // Signature register, reset to the seed.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig     = sig_q;
    assign sig_nxt = sisr_step(sig_q, din);

endmodule

// File: rtl/scan_signature_analyzer.sv
// Scan-BIST response analyzer: sequences scan_en for the multiplier scan chain
// on the shared dclk strobe, compacts scan_out during SHIFT phases and reports
// pass/fail against the golden signature after ROUNDS capture rounds.
module scan_signature_analyzer
    import scan_signature_analyzer_pkg::*;
#(
    parameter int         CHAIN_LEN = 8,
    parameter int         ROUNDS    = 4,
    parameter logic [7:0] SEED      = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dclk,
    input  logic       start,
    input  logic       scan_out,
    input  logic [7:0] golden,
    output logic       scan_en,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int RND_W = $clog2(ROUNDS + 1);

    localparam logic [CNT_W-1:0] LAST_STROBE = CNT_W'(CHAIN_LEN - 1);
    localparam logic [RND_W-1:0] LAST_ROUND  = RND_W'(ROUNDS);

    bist_state_e      state_q,   state_d;
    logic [CNT_W-1:0] strb_cnt_q, strb_cnt_d;
    logic [RND_W-1:0] rnd_cnt_q,  rnd_cnt_d;
    logic             scan_en_q, scan_en_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             pass_q,    pass_d;

    logic             sisr_load;
    logic             sisr_en;
    logic [7:0]       sig_nxt;

    sisr8 #(
        .SEED (SEED)
    ) u_sisr (
        .clk     (clk),
        .rst     (rst),
        .load    (sisr_load),
        .en      (sisr_en),
        .din     (scan_out),
        .sig     (sig),
        .sig_nxt (sig_nxt)
    );

    // Next-state, counter and result logic; everything advances only on a
    // dclk strobe, except start which acts alone and swallows a coincident strobe.
    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        rnd_cnt_d  = rnd_cnt_q;
        pass_d     = pass_q;
        sisr_load  = 1'b0;
        sisr_en    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    strb_cnt_d = '0;
                    rnd_cnt_d  = '0;
                    pass_d     = 1'b0;
                    sisr_load  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (dclk) begin
                    if (strb_cnt_q == LAST_STROBE) begin
                        state_d    = ST_CAPT;
                        strb_cnt_d = '0;
                    end else begin
                        strb_cnt_d = strb_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CAPT: begin
                if (dclk) begin
                    state_d    = ST_SHIFT;
                    strb_cnt_d = '0;
                    rnd_cnt_d  = rnd_cnt_q + RND_W'(1);
                end
            end
            ST_SHIFT: begin
                if (dclk) begin
                    sisr_en = 1'b1;
                    if (strb_cnt_q == LAST_STROBE) begin
                        strb_cnt_d = '0;
                        if (rnd_cnt_q == LAST_ROUND) begin
                            state_d = ST_DONE;
                            pass_d  = (sig_nxt == golden);
                        end else begin
                            state_d = ST_CAPT;
                        end
                    end else begin
                        strb_cnt_d = strb_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        scan_en_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_CAPT) || (state_d == ST_SHIFT);
        done_d    = (state_d == ST_DONE);
    end

    // Controller state, counters and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            strb_cnt_q <= '0;
            rnd_cnt_q  <= '0;
            scan_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            strb_cnt_q <= strb_cnt_d;
            rnd_cnt_q  <= rnd_cnt_d;
            scan_en_q  <= scan_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign scan_en = scan_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_scan_signature_analyzer.sv
// Directed bench for scan_signature_analyzer: a ROUNDS=1 and a ROUNDS=4
// instance share all inputs; a behavioural LFSR + multiplier scan chain
// supplies scan_out for the full-system cases.
module tb_scan_signature_analyzer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dclk = 1'b0;
    logic       start = 1'b0;
    logic       so_tb = 1'b0;
    logic [7:0] golden = 8'h00;
    logic       use_chain = 1'b0;
    logic       chain_init = 1'b0;
    logic       stuck = 1'b0;
    logic       scan_out;

    logic       scan_en1, busy1, done1, pass1;
    logic [7:0] sig1;
    logic       scan_en4, busy4, done4, pass4;
    logic [7:0] sig4;

    logic [7:0] lfsr;
    logic [7:0] chain;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign scan_out = use_chain ? chain[7] : so_tb;

    scan_signature_analyzer #(.CHAIN_LEN(8), .ROUNDS(1), .SEED(8'h00)) dut1 (
        .clk(clk), .rst(rst), .dclk(dclk), .start(start), .scan_out(scan_out),
        .golden(golden), .scan_en(scan_en1), .busy(busy1), .done(done1),
        .pass(pass1), .sig(sig1)
    );

    scan_signature_analyzer #(.CHAIN_LEN(8), .ROUNDS(4), .SEED(8'h00)) dut4 (
        .clk(clk), .rst(rst), .dclk(dclk), .start(start), .scan_out(scan_out),
        .golden(golden), .scan_en(scan_en4), .busy(busy4), .done(done4),
        .pass(pass4), .sig(sig4)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[3] ^ l[2] ^ l[1]};
    endfunction

    // Behavioural pattern LFSR and 8-SDFF chain: a = chain[7:4], b = chain[3:0].
    always @(posedge clk) begin
        if (chain_init) begin
            lfsr  <= 8'hA5;
            chain <= 8'h00;
        end else if (dclk) begin
            lfsr  <= lfsr_step(lfsr);
            if (scan_en4) chain <= {chain[6:0], lfsr[7]} | {7'd0, stuck};
            else          chain <= (8'(chain[7:4]) * 8'(chain[3:0])) | {7'd0, stuck};
        end
    end

    // Pure software reference of the full system for the given round count.
    task automatic model_sig(input bit stk, input int rounds, output logic [7:0] s);
        logic [7:0] l, c;
        l = 8'hA5; c = 8'h00; s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            c = {c[6:0], l[7]} | {7'd0, stk};
            l = lfsr_step(l);
        end
        for (int r = 0; r < rounds; r++) begin
            c = (8'(c[7:4]) * 8'(c[3:0])) | {7'd0, stk};
            l = lfsr_step(l);
            for (int i = 0; i < 8; i++) begin
                s = {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1] ^ c[7]};
                c = {c[6:0], l[7]} | {7'd0, stk};
                l = lfsr_step(l);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dclk = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One dclk-high cycle followed by one idle cycle; reports scan_en seen during the strobe.
    task automatic strobe(input logic so, output logic en1, output logic en4);
        @(negedge clk);
        dclk = 1'b1; so_tb = so;
        en1 = scan_en1; en4 = scan_en4;
        @(negedge clk);
        dclk = 1'b0;
    endtask

    // Strobe the selected instance until done; mode 0/1 = scan_out stuck 0/1,
    // mode 2 = scan_out 1 during LOAD only, mode 3 = real chain.
    task automatic run_to_done(input bit sel4, input int mode, output int n);
        logic e1, e4, so, d;
        n = 0;
        d = 1'b0;
        while (!d && n < 100) begin
            so = (mode == 1) || (mode == 2 && n < 8);
            strobe(so, e1, e4);
            n++;
            d = sel4 ? done4 : done1;
        end
        if (!d) check("done_timeout", 32'(n), 32'hFFFF);
    endtask

    typedef struct {
        string      name;
        bit         sel4;
        int         mode;
        logic [7:0] gold;
        logic [7:0] exp_sig;
        logic       exp_pass;
        int         exp_n;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       e1, e4;
        int         n;
        logic [7:0] good, bad;

        vecs[0] = '{"r1_one_gold_de",   1'b0, 1, 8'hDE, 8'hDE, 1'b1, 17};
        vecs[1] = '{"r1_one_gold_df",   1'b0, 1, 8'hDF, 8'hDE, 1'b0, 17};
        vecs[2] = '{"r1_zero",          1'b0, 0, 8'h00, 8'h00, 1'b1, 17};
        vecs[3] = '{"r4_zero",          1'b1, 0, 8'h00, 8'h00, 1'b1, 44};
        vecs[4] = '{"r4_one_load_only", 1'b1, 2, 8'h00, 8'h00, 1'b1, 44};

        // Reset state, then idle strobes change nothing.
        rst = 1'b1;
        #1;
        check("rst_scan_en", 32'(scan_en4), 0);
        check("rst_busy",    32'(busy4), 0);
        check("rst_done",    32'(done4), 0);
        check("rst_sig",     32'(sig4), 0);
        do_reset();
        for (int i = 0; i < 5; i++) strobe(1'b1, e1, e4);
        check("idle_scan_en", 32'(scan_en4), 0);
        check("idle_busy",    32'(busy4), 0);
        check("idle_done",    32'(done4), 0);
        check("idle_sig",     32'(sig4), 0);

        // ROUNDS=1 scan_en sequence and exact done timing.
        pulse_start();
        check("busy_after_start", 32'(busy1), 1);
        for (int i = 1; i <= 17; i++) begin
            strobe(1'b0, e1, e4);
            check($sformatf("scan_en_strobe%0d", i), 32'(e1), (i == 9) ? 0 : 1);
            if (i == 16) check("done_not_after_16", 32'(done1), 0);
        end
        check("done_after_17", 32'(done1), 1);
        check("busy_in_done",  32'(busy1), 0);

        // Table-driven full runs.
        foreach (vecs[k]) begin
            do_reset();
            golden = vecs[k].gold;
            pulse_start();
            run_to_done(vecs[k].sel4, vecs[k].mode, n);
            check({vecs[k].name, "_strobes"}, 32'(n), 32'(vecs[k].exp_n));
            check({vecs[k].name, "_sig"},  32'(vecs[k].sel4 ? sig4 : sig1), 32'(vecs[k].exp_sig));
            check({vecs[k].name, "_pass"}, 32'(vecs[k].sel4 ? pass4 : pass1), 32'(vecs[k].exp_pass));
        end

        // start pulsed mid-SHIFT is ignored; strobe count unchanged.
        do_reset();
        golden = 8'h00;
        pulse_start();
        for (int i = 0; i < 20; i++) strobe(1'b0, e1, e4);
        pulse_start();
        check("start_in_shift_busy", 32'(busy4), 1);
        run_to_done(1'b1, 0, n);
        check("start_in_shift_strobes", 32'(n + 20), 44);

        // start together with dclk from DONE: restart, seed reloaded, strobe not counted.
        do_reset();
        golden = 8'hDE;
        pulse_start();
        run_to_done(1'b0, 1, n);
        check("pre_restart_sig", 32'(sig1), 32'h00DE);
        @(negedge clk);
        start = 1'b1; dclk = 1'b1; so_tb = 1'b1;
        @(negedge clk);
        start = 1'b0; dclk = 1'b0;
        check("restart_sig",  32'(sig1), 0);
        check("restart_done", 32'(done1), 0);
        check("restart_pass", 32'(pass1), 0);
        check("restart_busy", 32'(busy1), 1);
        run_to_done(1'b0, 1, n);
        check("restart_strobes", 32'(n), 17);

        // rst on strobe 12 of 17 aborts at once; a fresh run then completes.
        do_reset();
        golden = 8'hDE;
        pulse_start();
        for (int i = 0; i < 11; i++) strobe(1'b1, e1, e4);
        @(negedge clk);
        dclk = 1'b1; rst = 1'b1;
        #1;
        check("abort_scan_en", 32'(scan_en1), 0);
        check("abort_busy",    32'(busy1), 0);
        check("abort_done",    32'(done1), 0);
        check("abort_pass",    32'(pass1), 0);
        check("abort_sig",     32'(sig1), 0);
        @(negedge clk);
        dclk = 1'b0; rst = 1'b0;
        pulse_start();
        run_to_done(1'b0, 1, n);
        check("fresh_strobes", 32'(n), 17);
        check("fresh_pass",    32'(pass1), 1);

        // Full system with the real chain, good and with chain bit 0 stuck at 1.
        model_sig(1'b0, 4, good);
        model_sig(1'b1, 4, bad);
        for (int f = 0; f < 2; f++) begin
            do_reset();
            use_chain = 1'b1;
            stuck = (f == 1);
            golden = good;
            @(negedge clk); chain_init = 1'b1;
            @(negedge clk); chain_init = 1'b0;
            pulse_start();
            run_to_done(1'b1, 3, n);
            check(f ? "chain_stuck_sig" : "chain_good_sig", 32'(sig4), 32'(f ? bad : good));
            check(f ? "chain_stuck_pass" : "chain_good_pass", 32'(pass4), (f == 0 || bad == good) ? 1 : 0);
        end
        use_chain = 1'b0;
        stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
